pacman_sprite_renderer: RTL
===========================

Name: pacman_sprite_renderer

Overview:
- Pixel-pipeline stage directly downstream of the 16x16 Pac-man sprite RAM (256 x 6-bit palette indices, 1-cycle registered read).
- Takes the VGA scan position and Pac-man's latched position and direction, and generates the sprite RAM read address with orientation applied.
- Realigns the RAM data with the delayed scan flags and emits a per-pixel palette index plus a hit flag for the colour mapper.
- Double-buffers position and direction at frame start so the sprite never tears mid-frame.

Parameters:
- SPRITE_DIM, 16, sprite edge length in pixels; must be a power of 2; RAM depth is SPRITE_DIM*SPRITE_DIM.
- COORD_W, 10, width of the DrawX/DrawY/PosX/PosY coordinates.
- TRANSPARENT_IDX, 0, palette index treated as see-through.

Ports:
- Clk  in  1  system clock (pixel-pipeline clock).
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the start of vertical blank.
- pix_valid  in  1  DrawX/DrawY are a visible pixel this cycle.
- DrawX  in  COORD_W  current scan column.
- DrawY  in  COORD_W  current scan row.
- PosX  in  COORD_W  sprite top-left column (live value from game logic).
- PosY  in  COORD_W  sprite top-left row (live value).
- dir  in  2  facing direction: 0 right, 1 left, 2 up, 3 down.
- ram_addr  out  8  read_address to the sprite RAM.
- ram_data  in  6  data_Out from the sprite RAM, valid 1 cycle after ram_addr.
- out_valid  out  1  pix_index/pix_hit correspond to a pixel.
- pix_hit  out  1  sprite covers this pixel and the pixel is opaque.
- pix_index  out  6  palette index; 0 when pix_hit=0.

Behaviour:
- Reset (async, Reset_n=0): all outputs 0. Shadow registers: sh_x=0, sh_y=0, sh_dir=0. All pipeline valid bits cleared.
- Shadow update: on a Clk edge with frame_start=1, capture PosX/PosY/dir into the shadow registers.
  - A pixel accepted in the same cycle as frame_start uses the old shadow values.
- Stage 1 (edge N+1):
  - dx = DrawX - sh_x and dy = DrawY - sh_y, computed COORD_W+1 bits wide.
  - in_box = pix_valid and 0 <= dx < SPRITE_DIM and 0 <= dy < SPRITE_DIM (a negative dx/dy is out of box).
  - Orientation, with M = SPRITE_DIM-1: right (u,v)=(dx,dy); left (M-dx, dy); up (dy, M-dx); down (dy, dx).
  - ram_addr <= v*SPRITE_DIM + u (the low 8 bits) when in_box; otherwise hold the previous value.
  - v1 <= pix_valid; box1 <= in_box.
- Stage 2 (edge N+2): the RAM registers ram_data; v2 <= v1, box2 <= box1.
- Stage 3 (edge N+3):
  - out_valid <= v2.
  - pix_hit <= box2 and (ram_data != TRANSPARENT_IDX).
  - pix_index <= pix_hit ? ram_data : 0.
- Latency: exactly 3 cycles from pix_valid to out_valid; throughput 1 pixel/cycle; no stalls or backpressure.
- Sprite partially off-screen (sh_x > 2^COORD_W - SPRITE_DIM): covered pixels beyond the screen edge never appear and nothing wraps to column 0, because of the COORD_W+1-bit subtract.
- pix_valid=0: the pipeline still advances, and out_valid falls 3 cycles later.
- Reset asserted mid-line: the pipeline flushes immediately. After release, out_valid stays 0 until 3 cycles after the next pix_valid.

Optional Feature:
- Macro: SPRITE_SCALE2_EN.
- Defined: the on-screen box is 2*SPRITE_DIM square. The in_box test uses 2*SPRITE_DIM, and (u,v) are computed from dx>>1 and dy>>1, giving pixel doubling. Latency is unchanged.
- Undefined: 1:1 rendering exactly as described in Behaviour.

Decomposition:
- Package pacman_sprite_pkg holds:
  - SPRITE_DIM and TRANSPARENT_IDX constants.
  - typedef enum logic [1:0] dir_t {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN}.
  - typedef for the sprite address.
- Sub-module sprite_addr_xform: combinational block, (dx, dy, dir) -> 8-bit address, instantiated in stage 1.

Test Plan:
- Reset, then PosX=100, PosY=50, dir=right, frame_start pulse, scan DrawX=100, DrawY=50, pix_valid=1 -> ram_addr=0 one cycle later; 3 cycles later out_valid=1 and pix_index equals RAM word 0.
- dir=left, DrawX=100, DrawY=50 -> ram_addr=15; dir=up -> ram_addr=240; dir=down -> ram_addr=0; dir=down at DrawX=101 -> ram_addr=16.
- RAM word 0 = 0 (transparent), in-box pixel -> pix_hit=0, pix_index=0, out_valid=1.
- PosX changes to 200 mid-frame without a frame_start -> pixels at X=100..115 still hit. After frame_start, X=200..215 hit and X=100 misses.
- PosX=1020, DrawX=1023 -> hit with u=3. DrawX=0..11 -> no hit (no wrap-around).
- Reset_n pulsed low during a scan burst -> out_valid=0 asynchronously; resumes exactly 3 cycles after pix_valid is reapplied.

Source files
------------

// File: rtl/pacman_sprite_pkg.sv
// pacman_sprite_pkg: shared constants and types for the Pac-man sprite renderer.
package pacman_sprite_pkg;
   localparam int SPRITE_DIM = 16;
   localparam logic [5:0] TRANSPARENT_IDX = 6'd0;
   typedef enum logic [1:0] {DIR_RIGHT, DIR_LEFT, DIR_UP, DIR_DOWN} dir_t;
   typedef logic [7:0] sprite_addr_t;
endpackage

// File: rtl/sprite_addr_xform.sv
// sprite_addr_xform: maps in-box sprite offsets and facing direction to a sprite RAM address.
module sprite_addr_xform
   import pacman_sprite_pkg::*;
#(
   parameter int DIM = SPRITE_DIM
) (
   input  logic [$clog2(DIM)-1:0] dx,
   input  logic [$clog2(DIM)-1:0] dy,
   input  dir_t                   dir,
   output sprite_addr_t           addr
);
   localparam int AW = $clog2(DIM);
   localparam logic [AW-1:0] M = AW'(DIM - 1);
   logic [AW-1:0] u, v;
   always_comb begin
      u = (dir == DIR_RIGHT) ? dx : (dir == DIR_LEFT) ? M - dx : dy;
      v = (dir == DIR_UP) ? M - dx : (dir == DIR_DOWN) ? dx : dy;
   end
   assign addr = sprite_addr_t'({v, u});
endmodule

// File: rtl/pacman_sprite_renderer.sv
// pacman_sprite_renderer: sprite RAM addressing and 3-cycle pixel pipeline for Pac-man.
// Define SPRITE_SCALE2_EN for a 2x pixel-doubled on-screen sprite.
module pacman_sprite_renderer #(
   parameter int         SPRITE_DIM      = pacman_sprite_pkg::SPRITE_DIM,
   parameter int         COORD_W         = 10,
   parameter logic [5:0] TRANSPARENT_IDX = pacman_sprite_pkg::TRANSPARENT_IDX
) (
   input  logic               Clk,
   input  logic               Reset_n,
   input  logic               frame_start,
   input  logic               pix_valid,
   input  logic [COORD_W-1:0] DrawX,
   input  logic [COORD_W-1:0] DrawY,
   input  logic [COORD_W-1:0] PosX,
   input  logic [COORD_W-1:0] PosY,
   input  logic [1:0]         dir,
   output logic [7:0]         ram_addr,
   input  logic [5:0]         ram_data,
   output logic               out_valid,
   output logic               pix_hit,
   output logic [5:0]         pix_index
);
   localparam int AW = $clog2(SPRITE_DIM);
`ifdef SPRITE_SCALE2_EN
   localparam int BOX = 2 * SPRITE_DIM;
`else
   localparam int BOX = SPRITE_DIM;
`endif
   logic [COORD_W-1:0] sh_x, sh_y;
   pacman_sprite_pkg::dir_t sh_dir;
   pacman_sprite_pkg::sprite_addr_t addr;
   logic [COORD_W:0] dx, dy;
   logic [AW-1:0] du, dv;
   logic in_box, hit, v1, box1, v2, box2;
   // The extra MSB makes left/above offsets huge, so they fail the box test instead of wrapping.
   assign dx = {1'b0, DrawX} - {1'b0, sh_x};
   assign dy = {1'b0, DrawY} - {1'b0, sh_y};
   assign in_box = pix_valid && dx < (COORD_W + 1)'(BOX) && dy < (COORD_W + 1)'(BOX);
`ifdef SPRITE_SCALE2_EN
   assign du = dx[AW:1];
   assign dv = dy[AW:1];
`else
   assign du = dx[AW-1:0];
   assign dv = dy[AW-1:0];
`endif
   assign hit = box2 && ram_data != TRANSPARENT_IDX;
   sprite_addr_xform #(.DIM(SPRITE_DIM)) u_xform (
      .dx  (du),
      .dy  (dv),
      .dir (sh_dir),
      .addr(addr)
   );
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         sh_x      <= '0;
         sh_y      <= '0;
         sh_dir    <= pacman_sprite_pkg::DIR_RIGHT;
         ram_addr  <= '0;
         v1        <= 1'b0;
         box1      <= 1'b0;
         v2        <= 1'b0;
         box2      <= 1'b0;
         out_valid <= 1'b0;
         pix_hit   <= 1'b0;
         pix_index <= '0;
      end else begin
         if (frame_start) begin
            sh_x   <= PosX;
            sh_y   <= PosY;
            sh_dir <= pacman_sprite_pkg::dir_t'(dir);
         end
         if (in_box) ram_addr <= addr;
         v1        <= pix_valid;
         box1      <= in_box;
         v2        <= v1;
         box2      <= box1;
         out_valid <= v2;
         pix_hit   <= hit;
         pix_index <= hit ? ram_data : '0;
      end
   end
endmodule
